// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline sequencer sitting between the execute stage and the front end
// (pc_reg, if_id, id_ex). Converts execute-stage jump/hold requests and
// memory-side holds into PC redirects plus per-stage stall and flush strobes.
// A jump that arrives while the pipe is held is parked and issued on the
// first cycle the hold releases. Stall cycles and redirects are counted in
// saturating perf counters.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active-low
//   jump_en_i       execute stage requests a redirect this cycle
//   jump_addr_i     redirect target
//   hold_flag_i     execute stage multi-cycle op busy
//   mem_hold_i      memory interface not ready
//   jump_en_o       redirect strobe to pc_reg
//   jump_addr_o     redirect target to pc_reg (0 when no redirect)
//   stall_o         {id_ex, if_id, pc} hold current contents
//   flush_o         {id_ex, if_id} load bubble
//   hold_timeout_o  one-cycle pulse every HOLD_TIMEOUT consecutive hold cycles
//   proto_err_o     sticky: jump requested while a flush was in progress
//   stall_cnt_o     cycles with any stall bit set (saturating)
//   flush_cnt_o     redirects issued (saturating)
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned HOLD_TIMEOUT = 1024,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_en_i,
    input  logic [63:0]      jump_addr_i,
    input  logic             hold_flag_i,
    input  logic             mem_hold_i,
    output logic             jump_en_o,
    output logic [63:0]      jump_addr_o,
    output logic [2:0]       stall_o,
    output logic [1:0]       flush_o,
    output logic             hold_timeout_o,
    output logic             proto_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam int unsigned HC_W = $clog2(HOLD_TIMEOUT) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1'b1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_TIMEOUT - 1);
    localparam logic [HC_W-1:0] HC_ONE  = HC_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [1:0]       state_q, state_d;
    logic [FC_W-1:0]  flush_ctr_q, flush_ctr_d;
    logic [HC_W-1:0]  hold_ctr_q, hold_ctr_d;
    logic             pend_v_q, pend_v_d;
    logic [63:0]      pend_addr_q, pend_addr_d;
    logic             proto_err_q, proto_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             hold_s;
    logic             jump_en_s;
    logic [63:0]      jump_addr_s;
    logic [2:0]       stall_s;
    logic [1:0]       flush_s;
    logic             hold_timeout_s;

    assign hold_s = hold_flag_i | mem_hold_i;

    // Sequencer next-state and strobe decode
    always_comb begin
        state_d     = state_q;
        flush_ctr_d = flush_ctr_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        proto_err_d = proto_err_q;
        jump_en_s   = 1'b0;
        jump_addr_s = 64'd0;
        stall_s     = 3'b000;
        flush_s     = 2'b00;

        case (state_q)
            // IDLE and HOLD share the decode: pend_v_q is never set in IDLE,
            // so the parked-jump path only ever fires on a HOLD exit.
            ST_IDLE, ST_HOLD: begin
                if (hold_s) begin
                    stall_s = 3'b111;
                    state_d = ST_HOLD;
                    // Only the first jump seen during a hold is kept.
                    if (jump_en_i && !pend_v_q) begin
                        pend_v_d    = 1'b1;
                        pend_addr_d = jump_addr_i;
                    end else begin
                        pend_v_d    = pend_v_q;
                    end
                end else if (pend_v_q || jump_en_i) begin
                    jump_en_s   = 1'b1;
                    jump_addr_s = pend_v_q ? pend_addr_q : jump_addr_i;
                    flush_s     = 2'b11;
                    pend_v_d    = 1'b0;
                    pend_addr_d = 64'd0;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flush_ctr_d = FC_LOAD;
                    end else begin
                        state_d     = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                flush_s     = 2'b11;
                proto_err_d = proto_err_q | jump_en_i;
                // A memory stall freezes the bubble count so no flush cycle
                // is lost while the front end is frozen.
                if (mem_hold_i) begin
                    stall_s = 3'b111;
                end else if (flush_ctr_q <= FC_ONE) begin
                    state_d     = ST_IDLE;
                    flush_ctr_d = {FC_W{1'b0}};
                end else begin
                    flush_ctr_d = flush_ctr_q - FC_ONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                flush_ctr_d = {FC_W{1'b0}};
                pend_v_d    = 1'b0;
            end
        endcase
    end

    // Hold watchdog: counts consecutive hold cycles and wraps at the timeout
    always_comb begin
        hold_timeout_s = hold_s && (hold_ctr_q == HC_LAST);
        if (!hold_s) begin
            hold_ctr_d = {HC_W{1'b0}};
        end else if (hold_ctr_q == HC_LAST) begin
            hold_ctr_d = {HC_W{1'b0}};
        end else begin
            hold_ctr_d = hold_ctr_q + HC_ONE;
        end
    end

    // Saturating perf counters
    always_comb begin
        if ((stall_s != 3'b000) && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (jump_en_s && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State, pending jump, watchdog and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            flush_ctr_q <= {FC_W{1'b0}};
            hold_ctr_q  <= {HC_W{1'b0}};
            pend_v_q    <= 1'b0;
            pend_addr_q <= 64'd0;
            proto_err_q <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            flush_ctr_q <= flush_ctr_d;
            hold_ctr_q  <= hold_ctr_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            proto_err_q <= proto_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Strobes are decoded from inputs, so they are masked while reset is
    // asserted to keep every output at zero during reset.
    assign jump_en_o      = rst & jump_en_s;
    assign jump_addr_o    = {64{rst}} & jump_addr_s;
    assign stall_o        = {3{rst}} & stall_s;
    assign flush_o        = {2{rst}} & flush_s;
    assign hold_timeout_o = rst & hold_timeout_s;
    assign proto_err_o    = proto_err_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

endmodule
